ram_logic: RTL and testbench

- Two-bank ping-pong sample buffer between a streaming producer (e.g. a filter/decimator output) and a block consumer.
- The producer fills one bank of DEPTH signed samples while the consumer drains the other bank.
- Banks swap automatically when the write bank is full and the read bank is empty.
- Valid/ready handshake on both sides, plus status and count outputs.

---
 rtl/ram_logic_pkg.sv | 11 +
 rtl/ram_logic_if.sv | 33 +++
 rtl/ram_logic_bank.sv | 26 ++
 rtl/ram_logic.sv | 112 +++++++++++
 tb/tb_ram_logic.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ram_logic_pkg.sv
// Shared defaults and types for the ram_logic ping-pong sample buffer.
package ram_logic_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

  typedef logic signed [DEF_WIDTH-1:0] sample_t;
  typedef logic [DEF_ADDR_WIDTH:0]     count_t;

endpackage

// File: rtl/ram_logic_if.sv
// Producer/consumer handshake and status bundle for ram_logic.
interface ram_logic_if
  import ram_logic_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic signed [WIDTH-1:0] write_data_i;
  logic                    write_valid_i;
  logic                    write_ready_o;
  logic signed [WIDTH-1:0] read_data_o;
  logic                    read_ready_i;
  logic                    read_valid_o;
  logic                    buffer_ready_o;
  logic                    buffer_overflow_o;
  logic [ADDR_WIDTH:0]     write_count_o;
  logic [ADDR_WIDTH:0]     read_count_o;

  // master: the producer/consumer side; slave: the buffer itself
  modport master (
    output write_data_i, write_valid_i, read_ready_i,
    input  write_ready_o, read_data_o, read_valid_o,
    input  buffer_ready_o, buffer_overflow_o, write_count_o, read_count_o
  );

  modport slave (
    input  write_data_i, write_valid_i, read_ready_i,
    output write_ready_o, read_data_o, read_valid_o,
    output buffer_ready_o, buffer_overflow_o, write_count_o, read_count_o
  );

endinterface

// File: rtl/ram_logic_bank.sv
// One DEPTH x WIDTH register bank: synchronous write, asynchronous read.
// Latency: write visible after the edge, read is combinational; no backpressure.
module ram_logic_bank #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_logic.sv
// Two-bank ping-pong sample buffer; 0-cycle read latency, write lands on the next edge.
// Backpressure: write_ready_o drops while both banks are full; RAM_LOGIC_STICKY_OVF_EN makes overflow sticky.
module ram_logic
  import ram_logic_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  ram_logic_if.slave bus
);

  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_LAST = cnt_t'(DEPTH - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  logic             wr_bank;
  logic             rd_full;
  cnt_t             write_count;
  cnt_t             read_count;
  logic             buffer_ready;
  logic             overflow;

  logic             write_ready;
  logic             wr_acc;
  logic             rd_acc;
  logic             rd_last;
  logic             wr_will_full;
  logic             rd_will_empty;
  logic             swap;
  logic             drop;
  logic [WIDTH-1:0] bank_rdata [2];

  assign write_ready   = (write_count != CNT_FULL);
  assign wr_acc        = bus.write_valid_i && write_ready;
  assign drop          = bus.write_valid_i && !write_ready;
  assign rd_acc        = rd_full && bus.read_ready_i;
  assign rd_last       = rd_acc && (read_count == CNT_LAST);

  // Swap once the write side is (or just became) full and the read side is (or just became) empty.
  assign wr_will_full  = !write_ready || (wr_acc && (write_count == CNT_LAST));
  assign rd_will_empty = !rd_full || rd_last;
  assign swap          = wr_will_full && rd_will_empty;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_logic_bank #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk_i),
      .we    (wr_acc && (wr_bank == 1'(b))),
      .waddr (write_count[ADDR_WIDTH-1:0]),
      .wdata (bus.write_data_i),
      .raddr (read_count[ADDR_WIDTH-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank      <= 1'b0;
      rd_full      <= 1'b0;
      write_count  <= '0;
      read_count   <= '0;
      buffer_ready <= 1'b0;
    end else begin
      buffer_ready <= swap;
      if (swap) begin
        wr_bank     <= ~wr_bank;
        write_count <= '0;
        read_count  <= '0;
        rd_full     <= 1'b1;
      end else begin
        if (wr_acc) begin
          write_count <= write_count + CNT_ONE;
        end
        if (rd_last) begin
          read_count <= '0;
          rd_full    <= 1'b0;
        end else if (rd_acc) begin
          read_count <= read_count + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow <= 1'b0;
    end else begin
`ifdef RAM_LOGIC_STICKY_OVF_EN
      overflow <= overflow | drop;
`else
      overflow <= drop;
`endif
    end
  end

  assign bus.write_ready_o     = write_ready;
  assign bus.read_valid_o      = rd_full;
  assign bus.read_data_o       = rd_full ? bank_rdata[~wr_bank] : '0;
  assign bus.buffer_ready_o    = buffer_ready;
  assign bus.buffer_overflow_o = overflow;
  assign bus.write_count_o     = write_count;
  assign bus.read_count_o      = read_count;

endmodule

// File: tb/tb_ram_logic.sv
// Directed bench for ram_logic with a queue-based model checked every cycle.
module tb_ram_logic;
  import ram_logic_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ram_logic_if #(.WIDTH(DEF_WIDTH), .ADDR_WIDTH(DEF_ADDR_WIDTH)) bus ();

  ram_logic #(.WIDTH(DEF_WIDTH), .DEPTH(DEF_DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bank is a queue of samples; a full write queue moves wholesale to the read side.
  logic [DEF_WIDTH-1:0] wq[$];
  logic [DEF_WIDTH-1:0] rq[$];
  bit                   m_bready;
  bit                   m_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit wacc, racc, dropped;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
      m_bready = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      wacc    = bus.write_valid_i && (wq.size() < DEPTH);
      dropped = bus.write_valid_i && (wq.size() >= DEPTH);
      racc    = bus.read_ready_i && (rq.size() > 0);
      if (racc) void'(rq.pop_front());
      if (wacc) wq.push_back(bus.write_data_i);
      m_bready = 1'b0;
      if (wq.size() == DEPTH && rq.size() == 0) begin
        rq = wq;
        wq.delete();
        m_bready = 1'b1;
      end
`ifdef RAM_LOGIC_STICKY_OVF_EN
      m_ovf = m_ovf | dropped;
`else
      m_ovf = dropped;
`endif
    end
  end

  always @(negedge clk) begin
    chk("m_write_ready", 64'(bus.write_ready_o), 64'(wq.size() < DEPTH));
    chk("m_read_valid",  64'(bus.read_valid_o),  64'(rq.size() > 0));
    chk("m_read_data",   64'(bus.read_data_o),   (rq.size() > 0) ? 64'(rq[0]) : 64'd0);
    chk("m_write_count", 64'(bus.write_count_o), 64'(wq.size()));
    chk("m_read_count",  64'(bus.read_count_o),  (rq.size() > 0) ? 64'(DEPTH - rq.size()) : 64'd0);
    chk("m_buf_ready",   64'(bus.buffer_ready_o), 64'(m_bready));
    chk("m_overflow",    64'(bus.buffer_overflow_o), 64'(m_ovf));
  end

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic tick(input logic wv, input logic [31:0] wd, input logic rr);
    bus.write_valid_i = wv;
    bus.write_data_i  = wd;
    bus.read_ready_i  = rr;
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_write_ready"}, 64'(bus.write_ready_o), 64'd1);
    chk({tag, "_read_valid"},  64'(bus.read_valid_o), 64'd0);
    chk({tag, "_read_data"},   64'(bus.read_data_o), 64'd0);
    chk({tag, "_write_count"}, 64'(bus.write_count_o), 64'd0);
    chk({tag, "_read_count"},  64'(bus.read_count_o), 64'd0);
    chk({tag, "_buf_ready"},   64'(bus.buffer_ready_o), 64'd0);
    chk({tag, "_overflow"},    64'(bus.buffer_overflow_o), 64'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.write_valid_i = 1'b0;
    bus.write_data_i  = '0;
    bus.read_ready_i  = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Write counting and first swap
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 32'h1000 + 32'(i), 1'b0);
      chk("cnt_step", 64'(bus.write_count_o), 64'(i + 1));
    end
    tick(1'b1, 32'h100F, 1'b0);
    chk("cnt_swap_wc", 64'(bus.write_count_o), 64'd0);
    chk("cnt_swap_rv", 64'(bus.read_valid_o), 64'd1);
    chk("cnt_swap_br", 64'(bus.buffer_ready_o), 64'd1);
    tick(1'b0, 32'h0, 1'b0);
    chk("cnt_br_once", 64'(bus.buffer_ready_o), 64'd0);
    repeat (DEPTH) tick(1'b0, 32'h0, 1'b1);

    // Readback
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h3000 + 32'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("rb_data", 64'(bus.read_data_o), 64'(32'h3000 + 32'(i)));
      tick(1'b0, 32'h0, 1'b1);
    end
    chk("rb_valid_drop", 64'(bus.read_valid_o), 64'd0);
    chk("rb_rc_zero",    64'(bus.read_count_o), 64'd0);

    // Ping-pong with simultaneous final read and final write
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h4000 + 32'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp_data_a", 64'(bus.read_data_o), 64'(32'h4000 + 32'(i)));
      tick(1'b1, 32'h5000 + 32'(i), 1'b1);
    end
    chk("pp_swap_br", 64'(bus.buffer_ready_o), 64'd1);
    chk("pp_swap_rv", 64'(bus.read_valid_o), 64'd1);
    chk("pp_swap_wc", 64'(bus.write_count_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp_data_b", 64'(bus.read_data_o), 64'(32'h5000 + 32'(i)));
      tick(1'b0, 32'h0, 1'b1);
    end

    // Both banks full, overflow, then drain both
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h6000 + 32'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h7000 + 32'(i), 1'b0);
    chk("full_wc", 64'(bus.write_count_o), 64'd16);
    chk("full_wr", 64'(bus.write_ready_o), 64'd0);
    tick(1'b1, 32'hDEADBEEF, 1'b0);
    chk("ovf_set", 64'(bus.buffer_overflow_o), 64'd1);
    chk("ovf_wc",  64'(bus.write_count_o), 64'd16);
    tick(1'b0, 32'h0, 1'b0);
`ifdef RAM_LOGIC_STICKY_OVF_EN
    chk("ovf_after", 64'(bus.buffer_overflow_o), 64'd1);
`else
    chk("ovf_after", 64'(bus.buffer_overflow_o), 64'd0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_data_a", 64'(bus.read_data_o), 64'(32'h6000 + 32'(i)));
      tick(1'b0, 32'h0, 1'b1);
    end
    chk("full_swap_br", 64'(bus.buffer_ready_o), 64'd1);
    chk("full_swap_wr", 64'(bus.write_ready_o), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_data_b", 64'(bus.read_data_o), 64'(32'h7000 + 32'(i)));
      tick(1'b0, 32'h0, 1'b1);
    end
    chk("full_drained", 64'(bus.read_valid_o), 64'd0);

    // Asynchronous reset between edges mid-fill
    for (int i = 0; i < 7; i++) tick(1'b1, 32'h8000 + 32'(i), 1'b0);
    chk("ar_wc_before", 64'(bus.write_count_o), 64'd7);
    bus.write_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 32'h9000, 1'b0);
    chk("ar_wc_after", 64'(bus.write_count_o), 64'd1);
    tick(1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
